mipi_frame_encoder: RTL and testbench

//  Transmit-side framer for the MIPI byte link: packs a byte stream (UART RX FIFO) into 48-bit words.

---
 rtl/mipi_frame_pkg.sv | 61 ++++++
 rtl/mipi_frame_encoder_fifo.sv | 49 ++++
 rtl/mipi_frame_encoder.sv | 246 ++++++++++++++++++++++++
 tb/tb_mipi_frame_encoder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mipi_frame_pkg.sv
// mipi_frame_pkg: definitions shared by the MIPI byte-link framer (TX) and the
// frame decoder (RX).
//   SOF_WORD / EOF_WORD  : 48-bit frame delimiters
//   META_*_LSB           : field offsets inside the 48-bit META word
//   enc_state_t          : encoder sequencer states
//   enc_mask()           : byte count of the last word -> byte-valid mask
//   build_meta()         : assemble a META word from its fields
//   byte_rev48()         : 48-bit word -> bus byte order (byte 5 lands on bus byte 0)
package mipi_frame_pkg;

  localparam logic [47:0] SOF_WORD = 48'hEAFF_99DE_ADFF;
  localparam logic [47:0] EOF_WORD = 48'hEAFF_99DE_ADAA;

  localparam int META_ID_LSB   = 40;
  localparam int META_DLEN_LSB = 16;
  localparam int META_MASK_LSB = 8;

  typedef enum logic [2:0] {
    ST_FILL = 3'd0,
    ST_SOF  = 3'd1,
    ST_META = 3'd2,
    ST_DATA = 3'd3,
    ST_EOF  = 3'd4,
    ST_GAP  = 3'd5
  } enc_state_t;

  // n = bytes in the final word. 0 means the final word was already pushed full.
  function automatic logic [7:0] enc_mask(input logic [2:0] n);
    logic [7:0] m;
    case (n)
      3'd1:    m = 8'h01;
      3'd2:    m = 8'h03;
      3'd3:    m = 8'h07;
      3'd4:    m = 8'h0F;
      3'd5:    m = 8'h1F;
      default: m = 8'h3F;
    endcase
    return m;
  endfunction

  function automatic logic [47:0] build_meta(input logic [7:0]  id,
                                             input logic [23:0] dlen,
                                             input logic [7:0]  mask);
    logic [47:0] m;
    m = 48'h0;
    m[META_ID_LSB   +: 8]  = id;
    m[META_DLEN_LSB +: 24] = dlen;
    m[META_MASK_LSB +: 8]  = mask;
    return m;
  endfunction

  function automatic logic [47:0] byte_rev48(input logic [47:0] w);
    logic [47:0] r;
    r = 48'h0;
    for (int k = 0; k < 6; k++) begin
      r[8*k +: 8] = w[40-8*k +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mipi_frame_encoder_fifo.sv
// mipi_frame_encoder_fifo: payload word buffer, 2**ADDR_WIDTH entries deep.
//   clk      : clock
//   rst_n    : synchronous active-low reset (clears pointers and data_out)
//   wr_en    : write data_in at the write pointer
//   data_in  : DATA_WIDTH write word
//   rd_en    : read; data_out is registered and valid the cycle after rd_en
//   data_out : DATA_WIDTH read word, held until the next read
// The caller never writes more entries than the depth before draining.
module mipi_frame_encoder_fifo #(
  parameter int DATA_WIDTH = 48,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;

  // Storage array; no reset so it can map onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= data_in;
    end
  end

  // Pointers and registered read port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      data_out <= '0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_en) begin
        data_out <= mem[rptr];
        rptr     <= rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mipi_frame_encoder.sv
// mipi_frame_encoder: packs an 8-bit byte stream into 48-bit words, buffers one
// frame, then emits SOF, META, DATA x dlen, EOF on the 64-bit MIPI TX bus.
//   tx_pixel_clk  : clock          rst           : synchronous active-high reset
//   app_id        : META id, taken on the first byte of a frame
//   s_data/s_valid/s_last/s_ready : byte input handshake (s_last ends a frame)
//   mipi_tx_data/mipi_tx_valid/mipi_tx_ready : bus output, [63:48] always zero
//   busy          : high from first accepted byte until the idle gap ends
// Optional build macro MIPI_ENC_TIMEOUT_EN: a held partial frame closes after
// TIMEOUT_CYCLES consecutive cycles with s_valid low.
module mipi_frame_encoder
  import mipi_frame_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int IDLE_GAP   = 4
`ifdef MIPI_ENC_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic        tx_pixel_clk,
  input  logic        rst,
  input  logic [7:0]  app_id,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [63:0] mipi_tx_data,
  output logic        mipi_tx_valid,
  input  logic        mipi_tx_ready,
  output logic        busy
);

  localparam int DW = ADDR_WIDTH + 1;
  localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam logic [DW-1:0] DLEN_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  enc_state_t    state;
  logic [47:0]   w;
  logic [2:0]    b;
  logic [DW-1:0] dlen;
  logic [DW-1:0] rcnt;
  logic [7:0]    mask;
  logic [7:0]    meta_id;
  logic [GW-1:0] gcnt;

  logic          accept;
  logic [47:0]   w_next;
  logic [2:0]    b_next;
  logic [DW-1:0] dlen_inc;
  logic [47:0]   w_d;
  logic [2:0]    b_d;
  logic          push;
  logic [47:0]   push_data;
  logic          close;
  logic [7:0]    close_mask;
  logic          rd_en;
  logic [47:0]   fifo_q;
  logic [23:0]   dlen24;
  logic          rst_n;

  assign rst_n    = ~rst;
  assign accept   = s_valid & s_ready & (state == ST_FILL);
  assign w_next   = {w[39:0], s_data};
  assign b_next   = b + 3'd1;
  assign dlen_inc = dlen + DW'(1);
  assign dlen24   = {{(24-DW){1'b0}}, dlen};

`ifdef MIPI_ENC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  logic          held;
  logic          to_hit;

  assign held   = (b != 3'd0) || (dlen != '0);
  assign to_hit = (state == ST_FILL) && !s_valid && held && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  // Idle-cycle counter; restarts on every accepted byte and outside FILL
  always_ff @(posedge tx_pixel_clk) begin
    if (rst) begin
      tcnt <= '0;
    end else if (state != ST_FILL || accept || !held || s_valid || to_hit) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end
`endif

  // Packer next-state: a word is pushed when it fills or the frame ends; a
  // partial last word keeps its bytes right-aligned because w restarts at zero.
  always_comb begin
    w_d        = w;
    b_d        = b;
    push       = 1'b0;
    push_data  = w_next;
    close      = 1'b0;
    close_mask = enc_mask(b_next);
    if (accept) begin
      if ((b == 3'd5) || s_last) begin
        push  = 1'b1;
        w_d   = 48'h0;
        b_d   = 3'd0;
        close = s_last || (dlen_inc == DLEN_MAX);
      end else begin
        w_d = w_next;
        b_d = b_next;
      end
    end else begin
`ifdef MIPI_ENC_TIMEOUT_EN
      if (to_hit) begin
        close      = 1'b1;
        close_mask = enc_mask(b);
        push       = (b != 3'd0);
        push_data  = w;
        w_d        = 48'h0;
        b_d        = 3'd0;
      end else begin
        close = 1'b0;
      end
`else
      close = 1'b0;
`endif
    end
  end

  // Buffer reads run one beat ahead so the next DATA word is already on fifo_q
  always_comb begin
    rd_en = 1'b0;
    case (state)
      ST_SOF:  rd_en = mipi_tx_ready;
      ST_META: rd_en = mipi_tx_ready && (dlen > DW'(1));
      ST_DATA: rd_en = mipi_tx_ready && (rcnt > DW'(1));
      default: rd_en = 1'b0;
    endcase
  end

  mipi_frame_encoder_fifo #(
    .DATA_WIDTH(48),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_fifo (
    .clk      (tx_pixel_clk),
    .rst_n    (rst_n),
    .wr_en    (push),
    .data_in  (push_data),
    .rd_en    (rd_en),
    .data_out (fifo_q)
  );

  // Sequencer: packing in FILL, then one word per accepted beat through the output register
  always_ff @(posedge tx_pixel_clk) begin
    if (rst) begin
      state         <= ST_FILL;
      s_ready       <= 1'b0;
      mipi_tx_data  <= 64'h0;
      mipi_tx_valid <= 1'b0;
      busy          <= 1'b0;
      w             <= 48'h0;
      b             <= 3'd0;
      dlen          <= '0;
      rcnt          <= '0;
      mask          <= 8'h00;
      meta_id       <= 8'h00;
      gcnt          <= '0;
    end else begin
      case (state)
        ST_FILL: begin
          w <= w_d;
          b <= b_d;
          if (push) begin
            dlen <= dlen_inc;
          end
          if (accept) begin
            busy <= 1'b1;
            if ((b == 3'd0) && (dlen == '0)) begin
              meta_id <= app_id;
            end
          end
          if (close) begin
            mask          <= close_mask;
            s_ready       <= 1'b0;
            mipi_tx_valid <= 1'b1;
            mipi_tx_data  <= {16'h0000, byte_rev48(SOF_WORD)};
            state         <= ST_SOF;
          end else begin
            s_ready <= 1'b1;
          end
        end
        ST_SOF: begin
          if (mipi_tx_ready) begin
            mipi_tx_data <= {16'h0000, byte_rev48(build_meta(meta_id, dlen24, mask))};
            state        <= ST_META;
          end
        end
        ST_META: begin
          if (mipi_tx_ready) begin
            mipi_tx_data <= {16'h0000, byte_rev48(fifo_q)};
            rcnt         <= dlen - DW'(1);
            state        <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (mipi_tx_ready) begin
            if (rcnt != '0) begin
              mipi_tx_data <= {16'h0000, byte_rev48(fifo_q)};
              rcnt         <= rcnt - DW'(1);
            end else begin
              mipi_tx_data <= {16'h0000, byte_rev48(EOF_WORD)};
              state        <= ST_EOF;
            end
          end
        end
        ST_EOF: begin
          if (mipi_tx_ready) begin
            mipi_tx_valid <= 1'b0;
            mipi_tx_data  <= 64'h0;
            gcnt          <= '0;
            if (IDLE_GAP == 0) begin
              state   <= ST_FILL;
              s_ready <= 1'b1;
              busy    <= 1'b0;
              dlen    <= '0;
              mask    <= 8'h00;
            end else begin
              state <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gcnt == GW'(IDLE_GAP - 1)) begin
            state   <= ST_FILL;
            s_ready <= 1'b1;
            busy    <= 1'b0;
            dlen    <= '0;
            mask    <= 8'h00;
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        end
        default: begin
          state   <= ST_FILL;
          s_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mipi_frame_encoder.sv
// tb_mipi_frame_encoder: directed self-checking bench for mipi_frame_encoder
// (ADDR_WIDTH=2 so a forced split happens at 24 bytes, IDLE_GAP=4).
module tb_mipi_frame_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  app_id;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [63:0] mipi_tx_data;
  logic        mipi_tx_valid;
  logic        mipi_tx_ready;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [63:0] beats[$];
  int          beat_cyc[$];

  localparam logic [63:0] SOF_B = 64'h0000_FFAD_DE99_FFEA;
  localparam logic [63:0] EOF_B = 64'h0000_AAAD_DE99_FFEA;

  always #5 clk = ~clk;

  mipi_frame_encoder #(
    .ADDR_WIDTH(2),
    .IDLE_GAP(4)
`ifdef MIPI_ENC_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .tx_pixel_clk  (clk),
    .rst           (rst),
    .app_id        (app_id),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_last        (s_last),
    .s_ready       (s_ready),
    .mipi_tx_data  (mipi_tx_data),
    .mipi_tx_valid (mipi_tx_valid),
    .mipi_tx_ready (mipi_tx_ready),
    .busy          (busy)
  );

  // Record every accepted bus beat with its cycle number
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && mipi_tx_valid && mipi_tx_ready) begin
      beats.push_back(mipi_tx_data);
      beat_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat(input int i);
    return (i < beats.size()) ? beats[i] : 64'hx;
  endfunction

  task automatic flush();
    beats.delete();
    beat_cyc.delete();
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    s_data = d; s_last = last; s_valid = 1'b1;
    while (s_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check("send_wait", {63'd0, s_ready}, 64'd1);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_beats(input int n, input string tag);
    int k;
    k = 0;
    while (beats.size() < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (beats.size() < n) check(tag, 64'(beats.size()), 64'(n));
  endtask

  initial begin
    rst = 1'b1; app_id = 8'h00; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0;
    mipi_tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_s_ready", {63'd0, s_ready}, 64'd0);
    check("rst_valid", {63'd0, mipi_tx_valid}, 64'd0);
    check("rst_data", mipi_tx_data, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("s_ready_rise", {63'd0, s_ready}, 64'd1);

    // Frame 1: 8 bytes, two words, partial last word
    flush();
    app_id = 8'h5A;
    for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
    check("f1_busy", {63'd0, busy}, 64'd1);
    wait_beats(5, "f1_count");
    check("f1_sof",  beat(0), SOF_B);
    check("f1_meta", beat(1), 64'h0000_0003_0200_005A);
    check("f1_d0",   beat(2), 64'h0000_0605_0403_0201);
    check("f1_d1",   beat(3), 64'h0000_0807_0000_0000);
    check("f1_eof",  beat(4), EOF_B);
    check("f1_nobubble", 64'(beat_cyc[4] - beat_cyc[0]), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check("gap_valid", {63'd0, mipi_tx_valid}, 64'd0);
      check("gap_busy", {63'd0, busy}, 64'd1);
      @(negedge clk);
    end
    check("gap_end_busy", {63'd0, busy}, 64'd0);
    check("gap_end_ready", {63'd0, s_ready}, 64'd1);

    // Frame 2: exactly one full word
    flush();
    app_id = 8'h33;
    for (int i = 0; i < 6; i++) send(8'hAA + 8'(i*17), i == 5);
    wait_beats(4, "f2_count");
    check("f2_sof",  beat(0), SOF_B);
    check("f2_meta", beat(1), 64'h0000_003F_0100_0033);
    check("f2_d0",   beat(2), 64'h0000_FFEE_DDCC_BBAA);
    check("f2_eof",  beat(3), EOF_B);

    // Frame 3: single byte
    repeat (6) @(negedge clk);
    flush();
    app_id = 8'h77;
    check("f3_idle_busy", {63'd0, busy}, 64'd0);
    send(8'h42, 1'b1);
    check("f3_busy", {63'd0, busy}, 64'd1);
    wait_beats(4, "f3_count");
    check("f3_meta", beat(1), 64'h0000_0001_0100_0077);
    check("f3_d0",   beat(2), 64'h0000_4200_0000_0000);
    check("f3_eof",  beat(3), EOF_B);

    // Frame 4: frame 1 with back-pressure on SOF and on the first DATA beat
    repeat (6) @(negedge clk);
    flush();
    mipi_tx_ready = 1'b0;
    app_id = 8'h5A;
    for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
    repeat (3) @(negedge clk);
    check("bp_sof_valid", {63'd0, mipi_tx_valid}, 64'd1);
    check("bp_sof_data", mipi_tx_data, SOF_B);
    mipi_tx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mipi_tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_d0_valid", {63'd0, mipi_tx_valid}, 64'd1);
      check("bp_d0_data", mipi_tx_data, 64'h0000_0605_0403_0201);
      @(negedge clk);
    end
    mipi_tx_ready = 1'b1;
    wait_beats(5, "bp_count");
    check("bp_sof",  beat(0), SOF_B);
    check("bp_meta", beat(1), 64'h0000_0003_0200_005A);
    check("bp_d0",   beat(2), 64'h0000_0605_0403_0201);
    check("bp_d1",   beat(3), 64'h0000_0807_0000_0000);
    check("bp_eof",  beat(4), EOF_B);
    check("bp_nodup", 64'(beats.size()), 64'd5);

    // Frame 5: 30 bytes, buffer fills at 24 and forces a split
    repeat (6) @(negedge clk);
    flush();
    app_id = 8'h11;
    for (int i = 1; i <= 30; i++) send(8'(i), i == 30);
    wait_beats(11, "split_count");
    check("split_sof",   beat(0),  SOF_B);
    check("split_meta",  beat(1),  64'h0000_003F_0400_0011);
    check("split_d0",    beat(2),  64'h0000_0605_0403_0201);
    check("split_d1",    beat(3),  64'h0000_0C0B_0A09_0807);
    check("split_d2",    beat(4),  64'h0000_1211_100F_0E0D);
    check("split_d3",    beat(5),  64'h0000_1817_1615_1413);
    check("split_eof",   beat(6),  EOF_B);
    check("split2_sof",  beat(7),  SOF_B);
    check("split2_meta", beat(8),  64'h0000_003F_0100_0011);
    check("split2_d0",   beat(9),  64'h0000_1E1D_1C1B_1A19);
    check("split2_eof",  beat(10), EOF_B);

    // Frame 6: reset during DATA, then a fresh 3-byte frame
    repeat (6) @(negedge clk);
    flush();
    app_id = 8'h5A;
    for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
    wait_beats(3, "rst_pre_count");
    mipi_tx_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", {63'd0, mipi_tx_valid}, 64'd0);
    check("midrst_data", mipi_tx_data, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", {63'd0, s_ready}, 64'd1);
    check("midrst_no_eof", {63'd0, mipi_tx_valid}, 64'd0);
    flush();
    mipi_tx_ready = 1'b1;
    app_id = 8'h99;
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b0);
    send(8'hC3, 1'b1);
    wait_beats(4, "rf_count");
    check("rf_sof",  beat(0), SOF_B);
    check("rf_meta", beat(1), 64'h0000_0007_0100_0099);
    check("rf_d0",   beat(2), 64'h0000_C3C2_C100_0000);
    check("rf_eof",  beat(3), EOF_B);

    // Idle input with a partial frame held
    repeat (6) @(negedge clk);
    flush();
    app_id = 8'hD0;
    send(8'hD1, 1'b0);
    send(8'hD2, 1'b0);
    send(8'hD3, 1'b0);
`ifdef MIPI_ENC_TIMEOUT_EN
    repeat (15) @(negedge clk);
    check("to_before", {63'd0, mipi_tx_valid}, 64'd0);
    @(negedge clk);
    check("to_close_valid", {63'd0, mipi_tx_valid}, 64'd1);
    check("to_close_sof", mipi_tx_data, SOF_B);
`else
    repeat (40) @(negedge clk);
    check("hold_valid", {63'd0, mipi_tx_valid}, 64'd0);
    check("hold_busy", {63'd0, busy}, 64'd1);
    check("hold_ready", {63'd0, s_ready}, 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
